// File: rtl/dbridge_pkg.sv
// Shared types and constants for the M-stage data bus bridge.
package dbridge_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} dbState_e;

  localparam logic [31:0] DBRIDGE_ERR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/data_bus_bridge_if.sv
// SRAM-like request/acknowledge data bus between the bridge (master) and memory (slave).
interface data_bus_bridge_if;
  logic        bus_req;
  logic        bus_wr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata,
    input  bus_addr_ok, bus_data_ok, bus_rdata
  );

  modport slave (
    input  bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata,
    output bus_addr_ok, bus_data_ok, bus_rdata
  );
endinterface

// File: rtl/dbridge_watchdog.sv
// Transaction watchdog: counts enabled cycles since clear, flags the LIMIT-th one.
module dbridge_watchdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  assign expire = en & (count == CW'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (rst || clr)        count <= '0;
    else if (en && !expire) count <= count + 1'b1;
  end
endmodule

// File: rtl/data_bus_bridge.sv
// M-stage load/store to request/ack bus bridge; stalls the core until the access completes.
// Optional watchdog timeout enabled by defining DBRIDGE_TIMEOUT_EN.
module data_bus_bridge
  import dbridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memenM,
  input  logic              memwriteM,
  input  logic [3:0]        memsel,
  input  logic [31:0]       aluoutM,
  input  logic [31:0]       final_writedM,
  input  logic              stall_otherM,
  output logic [31:0]       readdataM,
  output logic              stall_memM,
  data_bus_bridge_if.master bus,
  output logic              bus_err
);
  dbState_e    state, stateNext;
  logic        validAcc, acceptData, timeoutHit;
  logic        wrQ;
  logic [3:0]  strbQ;
  logic [31:0] addrQ, wdataQ;

  if (TIMEOUT_CYCLES < 1) begin : gBadTimeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  // Byte-less stores are dropped entirely: no bus traffic and no stall.
  assign validAcc   = memenM & ~(memwriteM & (memsel == 4'b0000));
  assign acceptData = ((state == REQ) & bus.bus_addr_ok & bus.bus_data_ok) |
                      ((state == WAIT) & bus.bus_data_ok);

`ifdef DBRIDGE_TIMEOUT_EN
  logic wdExpire, errQ;

  dbridge_watchdog #(.LIMIT(TIMEOUT_CYCLES)) uWatchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    ((state == IDLE) && validAcc),
    .en     ((state == REQ) || (state == WAIT)),
    .expire (wdExpire)
  );

  // A completion landing on the expiry cycle wins over the timeout.
  assign timeoutHit = wdExpire & ~acceptData;

  always_ff @(posedge clk) begin
    if (rst) errQ <= 1'b0;
    else     errQ <= timeoutHit;
  end

  assign bus_err = errQ;
`else
  assign timeoutHit = 1'b0;
  assign bus_err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext  = state;
    stall_memM = 1'b0;
    unique case (state)
      IDLE: if (validAcc) begin
        stall_memM = 1'b1;
        stateNext  = REQ;
      end
      REQ: begin
        stall_memM = 1'b1;
        if (bus.bus_addr_ok & bus.bus_data_ok) stateNext = DONE;
        else if (timeoutHit)                   stateNext = DONE;
        else if (bus.bus_addr_ok)              stateNext = WAIT;
      end
      WAIT: begin
        stall_memM = 1'b1;
        if (bus.bus_data_ok | timeoutHit) stateNext = DONE;
      end
      DONE: if (!stall_otherM) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Request fields come from the latched copy so they stay stable while the core is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrQ    <= 1'b0;
      strbQ  <= 4'b0000;
      addrQ  <= 32'h0;
      wdataQ <= 32'h0;
    end else if ((state == IDLE) && validAcc) begin
      wrQ    <= memwriteM;
      strbQ  <= memwriteM ? memsel : 4'b0000;
      addrQ  <= {aluoutM[31:2], 2'b00};
      wdataQ <= final_writedM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                      readdataM <= 32'h0;
    else if (acceptData & ~wrQ)   readdataM <= bus.bus_rdata;
    else if (timeoutHit & ~wrQ)   readdataM <= DBRIDGE_ERR_DATA;
  end

  assign bus.bus_req   = (state == REQ);
  assign bus.bus_wr    = wrQ;
  assign bus.bus_wstrb = strbQ;
  assign bus.bus_addr  = addrQ;
  assign bus.bus_wdata = wdataQ;
endmodule

// File: tb/tb_data_bus_bridge.sv
// Scoreboard bench for data_bus_bridge with a delay-programmable bus slave model.
module tb_data_bus_bridge;
`ifdef DBRIDGE_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic        clk = 1'b0, rst = 1'b1;
  logic        memenM = 1'b0, memwriteM = 1'b0, stall_otherM = 1'b0;
  logic [3:0]  memsel = 4'b0000;
  logic [31:0] aluoutM = 32'h0, final_writedM = 32'h0;
  logic [31:0] readdataM;
  logic        stall_memM, busErr;

  always #5 clk = ~clk;

  data_bus_bridge_if bif();

  data_bus_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .memenM        (memenM),
    .memwriteM     (memwriteM),
    .memsel        (memsel),
    .aluoutM       (aluoutM),
    .final_writedM (final_writedM),
    .stall_otherM  (stall_otherM),
    .readdataM     (readdataM),
    .stall_memM    (stall_memM),
    .bus           (bif),
    .bus_err       (busErr)
  );

  typedef struct {
    logic [31:0] rd;
    int          stalls;
  } sbEntry_t;

  sbEntry_t    sbQ[$];
  int          nTests = 0, nFail = 0;
  logic [31:0] lastRd = 32'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Slave: addr_ok on the (addrDly+1)-th REQ cycle, data_ok dataLag cycles after that.
  int          addrDly = 0, dataLag = 0, phase = 0, cnt = 0, reqCount = 0;
  logic [31:0] slvRdata = 32'h0;

  always @(negedge clk) begin
    if (rst) begin
      phase = 0; cnt = 0;
      bif.bus_addr_ok = 1'b0;
      bif.bus_data_ok = 1'b0;
      bif.bus_rdata   = 32'h0;
    end else begin
      case (phase)
        1: if (bif.bus_addr_ok) begin
             if (bif.bus_data_ok) phase = 0;
             else begin phase = 2; cnt = 1; end
           end else cnt++;
        2: if (bif.bus_data_ok) phase = 0; else cnt++;
        default: ;
      endcase
      if (phase == 0 && bif.bus_req) begin phase = 1; cnt = 0; reqCount++; end
      bif.bus_addr_ok = (phase == 1) && (cnt == addrDly);
      bif.bus_data_ok = ((phase == 1) && (cnt == addrDly) && (dataLag == 0)) ||
                        ((phase == 2) && (cnt == dataLag));
      bif.bus_rdata   = bif.bus_data_ok ? slvRdata : $urandom;
    end
  end

  task automatic access(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input int aD, input int dL, input int hold, input bit mute);
    sbEntry_t    e;
    int          stalls = 0;
    bit          done = 0;
    logic        valid;
    logic [31:0] rdHeld;
    valid    = !(we && sel == 4'b0000);
    e.stalls = !valid ? 0 : (mute ? 1 + TO : 2 + aD + dL);
    e.rd     = (valid && !we) ? (mute ? 32'hDEADBEEF : rdata) : lastRd;
    sbQ.push_back(e);
    @(negedge clk);
    addrDly = mute ? 100000 : aD;
    dataLag = dL;
    slvRdata = rdata;
    memenM = 1'b1; memwriteM = we; memsel = sel; aluoutM = addr; final_writedM = wdata;
    for (int c = 0; c < 400; c++) begin
      #2;
      if (!stall_memM) begin done = 1; break; end
      stalls++;
      if (c > 0) begin
        chk("busAddr", bif.bus_addr, {addr[31:2], 2'b00});
        chk("busWr", {31'h0, bif.bus_wr}, {31'h0, we});
        chk("busWstrb", {28'h0, bif.bus_wstrb}, {28'h0, we ? sel : 4'b0000});
        if (we) chk("busWdata", bif.bus_wdata, wdata);
      end
      @(negedge clk);
    end
    chk("completed", {31'h0, done}, 32'h1);
    if (!valid) chk("noReq", {31'h0, bif.bus_req}, 32'h0);
    e = sbQ.pop_front();
    chk("stallCycles", stalls, e.stalls);
    chk("readdataM", readdataM, e.rd);
    lastRd = e.rd;
`ifdef DBRIDGE_TIMEOUT_EN
    if (valid) chk("busErrPulse", {31'h0, busErr}, {31'h0, mute});
`endif
    if (hold > 0) begin
      rdHeld = readdataM;
      stall_otherM = 1'b1;
      for (int h = 1; h < hold; h++) begin
        @(negedge clk); #2;
        chk("heldNoReq", {31'h0, bif.bus_req}, 32'h0);
        chk("heldNoStall", {31'h0, stall_memM}, 32'h0);
        chk("heldRdata", readdataM, rdHeld);
      end
      @(negedge clk);
      stall_otherM = 1'b0;
    end
  endtask

  int reqBefore;

  initial begin
    repeat (3) @(negedge clk);
    #2;
    chk("rstReaddata", readdataM, 32'h0);
    chk("rstReq", {31'h0, bif.bus_req}, 32'h0);
    chk("rstWr", {31'h0, bif.bus_wr}, 32'h0);
    chk("rstWstrb", {28'h0, bif.bus_wstrb}, 32'h0);
    chk("rstAddr", bif.bus_addr, 32'h0);
    chk("rstWdata", bif.bus_wdata, 32'h0);
    chk("rstErr", {31'h0, busErr}, 32'h0);
    chk("rstStallIdle", {31'h0, stall_memM}, 32'h0);
    memenM = 1'b1;
    #1 chk("rstStallFollows", {31'h0, stall_memM}, 32'h1);
    memenM = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Zero-wait load.
    access(1'b0, 4'b1111, 32'h1000_0006, 32'h0, 32'h1122_3344, 0, 0, 0, 0);
    // Delayed store: addr_ok at cycle 3, data_ok two cycles later.
    access(1'b1, 4'b1100, 32'h2000_0012, 32'hABCD_0000, 32'h5555_AAAA, 2, 2, 0, 0);
    // Byte-less store is dropped.
    reqBefore = reqCount;
    access(1'b1, 4'b0000, 32'h3000_0000, 32'hFFFF_FFFF, 32'h0, 0, 0, 0, 0);
    @(negedge clk); memenM = 1'b0; #2;
    chk("dropNoReq", {31'h0, bif.bus_req}, 32'h0);
    chk("dropReqCount", reqCount - reqBefore, 0);
    // Assorted delays and a full-word store.
    access(1'b0, 4'b1111, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, 1, 0, 0, 0);
    access(1'b1, 4'b1111, 32'h0000_0200, 32'h1234_5678, 32'h0, 0, 1, 0, 0);
    // Held DONE, then back-to-back loads.
    reqBefore = reqCount;
    access(1'b0, 4'b1111, 32'h0000_0300, 32'h0, 32'h0BAD_CAFE, 0, 3, 4, 0);
    chk("heldReqCount", reqCount - reqBefore, 1);
    reqBefore = reqCount;
    access(1'b0, 4'b1111, 32'h0000_0404, 32'h0, 32'h7777_0001, 0, 0, 0, 0);
    access(1'b0, 4'b1111, 32'h0000_0408, 32'h0, 32'h7777_0002, 1, 1, 0, 0);
    @(negedge clk); memenM = 1'b0;
    repeat (2) @(negedge clk);
    chk("b2bReqCount", reqCount - reqBefore, 2);

    // Reset while in WAIT.
    addrDly = 0; dataLag = 50; slvRdata = 32'h9999_9999;
    memenM = 1'b1; memwriteM = 1'b0; memsel = 4'b1111; aluoutM = 32'h0000_0500;
    @(negedge clk); #2;
    chk("wtReq", {31'h0, bif.bus_req}, 32'h1);
    @(negedge clk); #2;
    chk("wtInWait", {30'h0, bif.bus_req, stall_memM}, 32'h1);
    rst = 1'b1; memenM = 1'b0;
    @(negedge clk); #2;
    chk("wtRstReq", {31'h0, bif.bus_req}, 32'h0);
    chk("wtRstRdata", readdataM, 32'h0);
    chk("wtRstStall", {31'h0, stall_memM}, 32'h0);
    rst = 1'b0; lastRd = 32'h0;
    @(negedge clk);
    access(1'b0, 4'b1111, 32'h0000_0600, 32'h0, 32'h4242_4242, 0, 0, 0, 0);

`ifdef DBRIDGE_TIMEOUT_EN
    // Slave never answers: watchdog must release the core.
    access(1'b0, 4'b1111, 32'h0000_0700, 32'h0, 32'h0, 0, 0, 0, 1);
    @(negedge clk); memenM = 1'b0; #2;
    chk("errOneCycle", {31'h0, busErr}, 32'h0);
    chk("toStallReleased", {31'h0, stall_memM}, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule

// File: doc/data_bus_bridge.md
# data_bus_bridge

Memory-stage data-side bridge between the pipelined MIPS core and an SRAM-like request/acknowledge data bus. It turns the core's single-cycle M-stage access (enable, write, byte selects, address, write data) into a multi-cycle bus transaction. It stalls the pipeline until the transaction completes, then returns the read word as `readdataM`. It sits directly downstream of the core's M-stage memory outputs and upstream of the data memory or bus interconnect.

## Interface
- `TIMEOUT_CYCLES`, default 255: watchdog limit in cycles; used only with `DBRIDGE_TIMEOUT_EN`.
- `clk`  in  1  core clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `memenM`  in  1  M-stage access enable.
- `memwriteM`  in  1  1 = store, 0 = load.
- `memsel`  in  4  byte enables for stores, bit i selects byte i.
- `aluoutM`  in  32  byte address.
- `final_writedM`  in  32  store data, already lane-aligned.
- `stall_otherM`  in  1  pipeline held by another source this cycle, e.g. the divider.
- `readdataM`  out  32  load data to the core.
- `stall_memM`  out  1  pipeline stall request.
- `bus_req`  out  1  request valid.
- `bus_wr`  out  1  write request.
- `bus_wstrb`  out  4  byte strobes; 0 for reads.
- `bus_addr`  out  32  word address `{aluoutM[31:2],2'b00}`.
- `bus_wdata`  out  32  store data.
- `bus_addr_ok`  in  1  request accepted this cycle.
- `bus_data_ok`  in  1  data returned or write completed this cycle.
- `bus_rdata`  in  32  read data, valid with `bus_data_ok`.
- `bus_err`  out  1  one-cycle timeout pulse; tied 0 without the macro.

## Operation
- FSM states are IDLE, REQ, WAIT, DONE.
- IDLE: on a valid access, latch address, write flag, strobes and data, then go to REQ.
  - Valid access = `memenM & ~(memwriteM & memsel==0)`.
  - A store with `memsel==0` is dropped: no bus traffic, no stall.
- REQ: `bus_req`=1, and the request fields are held stable from the latched copies.
  - `addr_ok` & `data_ok` in the same cycle: go to DONE.
  - `addr_ok` only: go to WAIT.
  - Otherwise: stay in REQ.
- WAIT: `bus_req`=0. `data_ok` moves to DONE.
- The read word is captured into the `readdataM` register on `data_ok` for loads only.
- `data_ok` is ignored outside WAIT, and outside REQ cycles that have `addr_ok`.
- DONE: `stall_memM`=0 so the pipeline advances.
  - If `stall_otherM`=1, stay in DONE. The same M-stage access is never reissued.
  - Otherwise go to IDLE.
- `stall_memM` = (IDLE & valid access) | REQ | WAIT. The IDLE term is combinational, so the core stalls in the detect cycle.
- `readdataM` holds its value until the next load completes.

## Timing
- Minimum load or store: 2 stall cycles.
  - Cycle 0: IDLE detects the access.
  - Cycle 1: REQ with `addr_ok` and `data_ok` both high.
  - Cycle 2: DONE, `readdataM` valid, no stall.
- Each extra cycle of `addr_ok` delay or `data_ok` delay adds one stall cycle.
- Back-to-back accesses: DONE → IDLE → detect, so the second access starts the cycle after DONE.
- Reset values: state IDLE, `bus_req` 0, `bus_wr` 0, `bus_wstrb` 0, `bus_addr` 0, `bus_wdata` 0, `readdataM` 0, `bus_err` 0.
  - `stall_memM` follows `memenM` in IDLE.
- Reset mid-transaction aborts to IDLE immediately. The bus slave shares `rst` and drops its outstanding transaction.
- Only one transaction is ever outstanding; there is no pipelining of bus requests.

## Configuration
- `DBRIDGE_TIMEOUT_EN` defined: a counter runs in REQ and WAIT and clears on entry to REQ.
  - When the count reaches `TIMEOUT_CYCLES` without completion, go to DONE and pulse `bus_err` for 1 cycle.
  - For loads, `readdataM` is set to 32'hDEADBEEF.
- Undefined: no counter; the bridge waits indefinitely; `bus_err` is tied 0.

## Structure
- `dbridge_pkg` holds:
  - the FSM state enum;
  - the `DBRIDGE_ERR_DATA` constant, 32'hDEADBEEF.
- Optional sub-module `dbridge_watchdog` holds the timeout counter with clear, enable and expire. It is instantiated only under `DBRIDGE_TIMEOUT_EN`.

## Test plan
- Zero-wait load: load from `aluoutM`=0x1000_0006.
  - Slave gives `addr_ok`+`data_ok` in the same cycle with `bus_rdata`=0x1122_3344.
  - Expect `bus_addr`=0x1000_0004, stall for exactly 2 cycles, `readdataM`=0x1122_3344.
- Delayed store: `memsel`=4'b1100, `final_writedM`=0xABCD_0000.
  - Slave gives `addr_ok` after 3 cycles and `data_ok` 2 cycles later.
  - Expect `bus_wstrb`=1100 and fields held stable throughout, 6 stall cycles.
- Store with `memsel`=0: expect no `bus_req` and `stall_memM`=0.
- Held DONE: `stall_otherM`=1 for 4 cycles at DONE.
  - Expect no second `bus_req` and `readdataM` stable.
  - Back-to-back loads then produce exactly 2 bus requests.
- Reset while in WAIT: expect IDLE next cycle, `bus_req`=0, `readdataM`=0.
- With `DBRIDGE_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8: a load with no `data_ok` gives a `bus_err` pulse, `readdataM`=0xDEADBEEF, and the stall released.
